store_buffer: RTL and testbench
===============================

# store_buffer

Write buffer between the MEM pipeline stage and the single-port `dataMemory`. Pipeline stores are queued in a small in-order FIFO and written to memory only in cycles where the pipeline is not using the memory port. Loads are served from the youngest matching buffered store, or from memory when no entry matches. A fence input drains the buffer completely before the pipeline proceeds.

## Interface
- `DEPTH`, default 4. Number of store entries; power of two, ≥2.
- `AW`, default 32. Address width.
- `DW`, default 32. Data width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `st_valid` in 1: pipeline store request (MEM-stage memWrite).
- `ld_valid` in 1: pipeline load request (MEM-stage memRead).
- `fence` in 1: drain request; asserted alone, with no load or store.
- `address` in AW: pipeline word address.
- `wdata` in DW: pipeline store data.
- `rdata` out DW: load data to the pipeline.
- `stall` out 1: pipeline must hold MEM and all earlier stages this cycle.
- `empty` out 1: buffer holds no entries.
- `mem_read` out 1: to `dataMemory.memRead`.
- `mem_write` out 1: to `dataMemory.memWrite`.
- `mem_addr` out AW: to `dataMemory.address`.
- `mem_wdata` out DW: to `dataMemory.writeData`.
- `mem_rdata` in DW: from `dataMemory.readData`, combinational read.

## Operation
- **State:** circular FIFO of {addr, data}; head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; count register 0..DEPTH. full = (count == DEPTH).
- **Request priority:**
  - `ld_valid` overrides `st_valid`. If both are asserted, the store is ignored; the bench flags this as illegal.
  - `fence` with any other request is illegal.
- **Drain condition (`drain`):** count > 0 and one of:
  - no `ld_valid` and no `st_valid`;
  - `st_valid` with full;
  - `fence`.
- **Drain action:** `mem_write`=1, `mem_addr`/`mem_wdata` = head entry. Head is popped at the next rising edge. `dataMemory` commits the write on the falling edge inside the same cycle.
- **Store:**
  - Not full: enqueued at the tail at the rising edge; `stall`=0.
  - Full: `stall`=1, head drains, nothing is enqueued. The pipeline re-presents the store the next cycle, when it is accepted. Each full-buffer store therefore costs exactly one stall cycle.
- **Store coalescing:** none. Repeated stores to one address occupy separate entries and drain in program order.
- **Load:**
  - Entries are searched youngest to oldest for an exact address match.
  - Hit: `rdata` = youngest matching data, `mem_read`=0.
  - Miss: `mem_read`=1, `mem_addr`=`address`, `rdata`=`mem_rdata`.
  - No drain occurs in a load cycle.
  - A store enqueued in cycle N is visible to a load in cycle N+1.
- **Fence:** `stall` = `fence` && !`empty`. One entry drains per cycle until empty.
- **Idle port:** when not draining and not on a load miss, `mem_read`=`mem_write`=0 and `mem_addr` = `address`.
- `rdata` = 0 when `ld_valid`=0.

## Timing
- **Reset:** count=0, pointers=0, entry contents don't-care. Resulting outputs:
  - `empty`=1, `mem_write`=0;
  - `stall`=0 (no fence can stall while empty);
  - `mem_read` follows `ld_valid`.
- **Latency:**
  - Load: zero cycles; `rdata` is combinational within the request cycle, for both hit and miss.
  - Store acceptance: one edge.
  - Memory visibility: at the earliest, the first drain cycle after enqueue.
- **Simultaneous store + drain while full:** pop only; the push happens next cycle. Count never exceeds DEPTH.
- **Reset mid-operation:** all buffered stores are discarded and never written. A `mem_write` pulse in progress is cut off asynchronously.
- **Other outputs:** `stall`, `empty` and all `mem_*` outputs are combinational from state and current inputs, with no registered outputs.

## Structure
- **Package `store_buffer_pkg`:**
  - `DEPTH`/`AW`/`DW` defaults;
  - `sb_entry_t` struct {addr, data};
  - pointer-width constant `PTR_W = $clog2(DEPTH)`.
- **Sub-module `sb_fwd_match`:**
  - Combinational youngest-first priority matcher.
  - Inputs: entry array, valid mask, tail pointer, lookup address.
  - Outputs: hit and data.
- **Top level:** FIFO pointers, count, drain/stall logic and port muxing.

## Test plan
- Reset → `empty`=1, `mem_write`=0, `stall`=0. Then `ld_valid` at address 3 → `rdata`=7 (`dataMemory` reset image).
- Stores (4,0xA), (8,0xB), (12,0xC), then 3 idle cycles → `mem_write` on each idle cycle at 4, 8, 12 in order; `empty`=1 after the third.
- Store (3,0x55), next cycle load 3 → `rdata`=0x55, `mem_read`=0.
- Store (5,0x1), store (5,0x2), load 5 → `rdata`=0x2. After drain, memory[5]=0x2.
- Five back-to-back stores with DEPTH=4 → `stall`=1 only on the first presentation of store 5, with address-0 entry draining that cycle. Store 5 is accepted next cycle; all five reach memory in order.
- Two buffered stores, then `fence` → `stall`=1 for 2 cycles, then 0. Repeat with `rst` pulsed mid-fence → `empty`=1 immediately, remaining entry never written.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared constants and types for the MEM-stage store buffer.
//   SB_DEPTH/SB_AW/SB_DW are the default geometry of store_buffer.
//   sb_entry_t is one buffered store {addr, data} at the default widths.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int PTR_W    = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match
//   Combinational store-to-load forwarding matcher. It searches the
//   buffered entries from youngest to oldest and returns the data of the
//   youngest valid entry whose address equals the lookup address.
// Ports:
//   ent_addr_i / ent_data_i : entry storage, indexed by FIFO slot
//   valid_i                 : per-slot occupancy mask
//   tail_i                  : next write slot (slot tail-1 is the youngest)
//   lookup_addr_i           : load address
//   hit_o / data_o          : match found / youngest matching data
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] ent_addr_i,
  input  logic [DEPTH-1:0][DW-1:0] ent_data_i,
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [PW-1:0]            tail_i,
  input  logic [AW-1:0]            lookup_addr_i,
  output logic                     hit_o,
  output logic [DW-1:0]            data_o
);

  logic [PW-1:0] idx;

  // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); a later
  // match overwrites an earlier one, so the youngest match wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - PW'(k);
      if (valid_i[idx] && (ent_addr_i[idx] == lookup_addr_i)) begin
        hit_o  = 1'b1;
        data_o = ent_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   In-order write buffer between the MEM stage and a single-port data
//   memory. Stores are queued and written back only in cycles where the
//   pipeline leaves the memory port free; loads forward from the youngest
//   matching buffered store or read memory on a miss; fence drains all.
// Ports:
//   clk, rst (async, active-high)
//   st_valid/ld_valid/fence, address, wdata : pipeline request
//   rdata, stall                             : pipeline response
//   empty                                    : buffer holds no entries
//   mem_read/mem_write/mem_addr/mem_wdata    : data memory port
//   mem_rdata                                : combinational memory read data
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic          ld_valid,
  input  logic          fence,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          empty,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DEPTH-1:0][AW-1:0] ent_addr_q;
  logic [DEPTH-1:0][DW-1:0] ent_data_q;

  logic                     full;
  logic                     st_eff;
  logic                     push;
  logic                     drain;
  logic [DEPTH-1:0]         valid;
  logic [PW-1:0]            rel;
  logic                     fwd_hit;
  logic [DW-1:0]            fwd_data;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // A load wins the port; a store presented alongside it is dropped.
  assign st_eff = st_valid && !ld_valid;
  assign push   = st_eff && !full;
  assign drain  = !empty && !ld_valid &&
                  ((!st_valid) || (st_valid && full) || fence);
  assign stall  = (st_eff && full) || (fence && !empty);

  // Slot i is occupied when its distance from head is below count.
  always_comb begin
    valid = '0;
    rel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel      = PW'(i) - head_q;
      valid[i] = (CW'(rel) < count_q);
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .ent_addr_i    (ent_addr_q),
    .ent_data_i    (ent_data_q),
    .valid_i       (valid),
    .tail_i        (tail_q),
    .lookup_addr_i (address),
    .hit_o         (fwd_hit),
    .data_o        (fwd_data)
  );

  always_comb begin
    mem_write = drain;
    mem_read  = ld_valid && !fwd_hit;
    mem_addr  = drain ? ent_addr_q[head_q] : address;
    mem_wdata = drain ? ent_data_q[head_q] : wdata;
    rdata     = '0;
    if (ld_valid) begin
      rdata = fwd_hit ? fwd_data : mem_rdata;
    end
  end

  always_comb begin
    head_d  = drain ? head_q + PW'(1) : head_q;
    tail_d  = push  ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (push && !drain) begin
      count_d = count_q + CW'(1);
    end else if (drain && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= address;
      ent_data_q[tail_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        st_valid, ld_valid, fence;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        stall, empty, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] dmem [64];

  int vectors = 0;
  int miscompares = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .ld_valid  (ld_valid),
    .fence     (fence),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .empty     (empty),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // dataMemory stand-in: combinational read, write committed on falling edge.
  assign mem_rdata = dmem[mem_addr[5:0]];
  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = 32'(2 * i + 1);
    forever begin
      @(negedge clk);
      if (mem_write) dmem[mem_addr[5:0]] = mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: queue of pending stores + memory image
  sb_entry_t   mq[$];
  logic [31:0] ref_mem [64];
  logic        e_stall, e_mw, e_mr, e_empty, do_push, do_pop;
  logic [31:0] e_maddr, e_wdata, e_rdata;
  sb_entry_t   pend;

  task automatic model_eval(input logic st, input logic ld, input logic fn,
                            input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic hit;
    n = mq.size();
    e_stall = 0; e_mw = 0; e_mr = 0; e_rdata = 0; e_maddr = a; e_wdata = wd;
    e_empty = (n == 0); do_push = 0; do_pop = 0; hit = 0;
    pend.addr = a; pend.data = wd;
    if (ld) begin
      for (int i = n - 1; i >= 0 && !hit; i--) begin
        if (mq[i].addr == a) begin
          hit = 1;
          e_rdata = mq[i].data;
        end
      end
      if (!hit) begin
        e_mr = 1;
        e_rdata = ref_mem[a[5:0]];
      end
    end else if (st) begin
      if (n == DEPTH) begin
        e_stall = 1;
        do_pop = 1;
      end else begin
        do_push = 1;
      end
    end else if (fn) begin
      if (n > 0) begin
        e_stall = 1;
        do_pop = 1;
      end
    end else if (n > 0) begin
      do_pop = 1;
    end
    if (do_pop) begin
      e_mw = 1;
      e_maddr = mq[0].addr;
      e_wdata = mq[0].data;
    end
  endtask

  task automatic model_commit();
    if (do_pop) begin
      ref_mem[mq[0].addr[5:0]] = mq[0].data;
      void'(mq.pop_front());
    end
    if (do_push) mq.push_back(pend);
  endtask

  // Called at posedge+1: drive, then wait to posedge+4 (before the negedge write).
  task automatic drive(input logic st, input logic ld, input logic fn,
                       input logic [31:0] a, input logic [31:0] wd);
    st_valid = st; ld_valid = ld; fence = fn; address = a; wdata = wd;
    model_eval(st, ld, fn, a, wd);
    #3;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // ---------------- directed table
  typedef struct {
    logic        st, ld, fn;
    logic [31:0] addr, wd;
    logic        x_stall, x_mw, x_mr, x_empty;
    logic [31:0] x_maddr, x_wdata, x_rdata;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic st, input logic ld, input logic fn,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic s, input logic mw, input logic mr, input logic em,
                     input logic [31:0] ma, input logic [31:0] mwd, input logic [31:0] rd);
    vec_t v;
    v.st = st; v.ld = ld; v.fn = fn; v.addr = a; v.wd = wd;
    v.x_stall = s; v.x_mw = mw; v.x_mr = mr; v.x_empty = em;
    v.x_maddr = ma; v.x_wdata = mwd; v.x_rdata = rd;
    vt.push_back(v);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " stall"}, 32'(stall), 32'(e_stall));
    chk({tag, " empty"}, 32'(empty), 32'(e_empty));
    chk({tag, " mem_write"}, 32'(mem_write), 32'(e_mw));
    chk({tag, " mem_read"}, 32'(mem_read), 32'(e_mr));
    chk({tag, " mem_addr"}, mem_addr, e_maddr);
    chk({tag, " rdata"}, rdata, e_rdata);
    if (e_mw) chk({tag, " mem_wdata"}, mem_wdata, e_wdata);
  endtask

  initial begin
    logic        r_st, r_ld, r_fn;
    logic [31:0] r_a, r_wd;
    logic        hold;
    int          op;

    rst = 1; st_valid = 0; ld_valid = 0; fence = 0; address = 0; wdata = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(2 * i + 1);

    //  st ld fn addr   wd     stall mw mr empty maddr  wdata  rdata
    add(0, 0, 0, 0,     0,     0, 0, 0, 1, 0,     0,     0);
    add(0, 1, 0, 3,     0,     0, 0, 1, 1, 3,     0,     7);
    add(1, 0, 0, 4,     'hA,   0, 0, 0, 1, 4,     0,     0);
    add(1, 0, 0, 8,     'hB,   0, 0, 0, 0, 8,     0,     0);
    add(1, 0, 0, 12,    'hC,   0, 0, 0, 0, 12,    0,     0);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 4,     'hA,   0);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 8,     'hB,   0);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 12,    'hC,   0);
    add(0, 0, 0, 0,     0,     0, 0, 0, 1, 0,     0,     0);
    add(1, 0, 0, 3,     'h55,  0, 0, 0, 1, 3,     0,     0);
    add(0, 1, 0, 3,     0,     0, 0, 0, 0, 3,     0,     'h55);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 3,     'h55,  0);
    add(1, 0, 0, 5,     1,     0, 0, 0, 1, 5,     0,     0);
    add(1, 0, 0, 5,     2,     0, 0, 0, 0, 5,     0,     0);
    add(0, 1, 0, 5,     0,     0, 0, 0, 0, 5,     0,     2);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 5,     1,     0);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 5,     2,     0);
    add(0, 1, 0, 5,     0,     0, 0, 1, 1, 5,     0,     2);
    add(1, 0, 0, 0,     'h10,  0, 0, 0, 1, 0,     0,     0);
    add(1, 0, 0, 1,     'h11,  0, 0, 0, 0, 1,     0,     0);
    add(1, 0, 0, 2,     'h12,  0, 0, 0, 0, 2,     0,     0);
    add(1, 0, 0, 3,     'h13,  0, 0, 0, 0, 3,     0,     0);
    add(1, 0, 0, 4,     'h14,  1, 1, 0, 0, 0,     'h10,  0);
    add(1, 0, 0, 4,     'h14,  0, 0, 0, 0, 4,     0,     0);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 1,     'h11,  0);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 2,     'h12,  0);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 3,     'h13,  0);
    add(0, 0, 0, 0,     0,     0, 1, 0, 0, 4,     'h14,  0);
    add(0, 0, 0, 0,     0,     0, 0, 0, 1, 0,     0,     0);
    add(1, 0, 0, 6,     'h66,  0, 0, 0, 1, 6,     0,     0);
    add(1, 0, 0, 7,     'h77,  0, 0, 0, 0, 7,     0,     0);
    add(0, 0, 1, 0,     0,     1, 1, 0, 0, 6,     'h66,  0);
    add(0, 0, 1, 0,     0,     1, 1, 0, 0, 7,     'h77,  0);
    add(0, 0, 1, 0,     0,     0, 0, 0, 1, 0,     0,     0);

    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].st, vt[i].ld, vt[i].fn, vt[i].addr, vt[i].wd);
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(vt[i].x_stall));
      chk($sformatf("row%0d mem_write", i), 32'(mem_write), 32'(vt[i].x_mw));
      chk($sformatf("row%0d mem_read", i), 32'(mem_read), 32'(vt[i].x_mr));
      chk($sformatf("row%0d empty", i), 32'(empty), 32'(vt[i].x_empty));
      chk($sformatf("row%0d mem_addr", i), mem_addr, vt[i].x_maddr);
      chk($sformatf("row%0d rdata", i), rdata, vt[i].x_rdata);
      if (vt[i].x_mw) chk($sformatf("row%0d mem_wdata", i), mem_wdata, vt[i].x_wdata);
      next_cycle();
    end

    chk("mem[0]", dmem[0], 32'h10);
    chk("mem[3]", dmem[3], 32'h13);
    chk("mem[4]", dmem[4], 32'h14);
    chk("mem[5]", dmem[5], 32'h2);
    chk("mem[6]", dmem[6], 32'h66);
    chk("mem[7]", dmem[7], 32'h77);
    chk("mem[8]", dmem[8], 32'hB);
    chk("mem[12]", dmem[12], 32'hC);

    // Reset in the middle of a fence: second entry must never reach memory.
    drive(1, 0, 0, 20, 32'h20); next_cycle();
    drive(1, 0, 0, 21, 32'h21); next_cycle();
    drive(0, 0, 1, 0, 0);
    chk("rstfence stall0", 32'(stall), 32'd1);
    chk("rstfence addr0", mem_addr, 32'd20);
    next_cycle();
    fence = 1;
    #1 rst = 1;
    #1;
    chk("rstfence empty", 32'(empty), 32'd1);
    chk("rstfence mem_write", 32'(mem_write), 32'd0);
    chk("rstfence stall", 32'(stall), 32'd0);
    @(posedge clk);
    mq.delete();
    #1 rst = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, (i == 0), 0, 0);
      check_model($sformatf("postrst%0d", i));
      next_cycle();
    end
    chk("mem[20]", dmem[20], 32'h20);
    chk("mem[21]", dmem[21], 32'd43);

    // Randomized traffic against the queue model.
    hold = 0; r_st = 0; r_ld = 0; r_fn = 0; r_a = 0; r_wd = 0;
    for (int c = 0; c < 500; c++) begin
      if (!hold) begin
        op = $urandom_range(0, 9);
        r_st = (op <= 3);
        r_ld = (op >= 4 && op <= 6);
        r_fn = (op == 7);
        r_a  = 32'($urandom_range(0, 15));
        r_wd = $urandom;
      end
      drive(r_st, r_ld, r_fn, r_a, r_wd);
      check_model($sformatf("rnd%0d", c));
      hold = e_stall;
      next_cycle();
    end
    for (int c = 0; c < DEPTH + 1; c++) begin
      drive(0, 0, 0, 0, 0);
      check_model($sformatf("flush%0d", c));
      next_cycle();
    end
    for (int i = 0; i < 64; i++) chk($sformatf("final mem[%0d]", i), dmem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
